// File: rtl/riscv_pkg.sv
// Shared types for the core's memory-side bus logic.
package riscv_pkg;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } bus_owner_e;

    typedef enum logic [1:0] {
        LOCK_NONE  = 2'd0,
        LOCK_INSTR = 2'd1,
        LOCK_DATA  = 2'd2
    } lock_state_e;

    localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/owner_fifo.sv
// In-order record of which master owns each granted, not yet answered transaction.
module owner_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  bus_owner_e push_owner,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output bus_owner_e head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    bus_owner_e    mem_q [DEPTH];
    bus_owner_e    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == COUNT_MAX);
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_owner;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= OWN_INSTR;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates fetch and load/store requests onto one memory port and routes
// in-order responses back to the master that issued each transaction.
module bus_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned OUTSTANDING  = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_gnt,
    output logic [31:0] instr_rdata,
    output logic        instr_err,
    output logic        instr_valid,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_byteen,
    output logic        data_gnt,
    output logic [31:0] data_rdata,
    output logic        data_valid,
    output logic        slv_req,
    output logic        slv_wr,
    output logic [31:0] slv_addr,
    output logic [31:0] slv_wdata,
    output logic [3:0]  slv_be,
    input  logic        slv_gnt,
    input  logic [31:0] slv_rdata,
    input  logic        slv_err,
    input  logic        slv_valid,
    output logic        rsp_err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    lock_state_e lock_q, lock_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;

    logic       sel_valid;
    bus_owner_e sel_owner;
    logic       fifo_full, fifo_empty;
    bus_owner_e fifo_head;
    logic       rsp_routed;

    // Lock register
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q       <= LOCK_NONE;
            starve_cnt_q <= '0;
        end else begin
            lock_q       <= lock_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // A stalled request pins the selection until memory accepts it.
    always_comb begin
        lock_d = lock_q;
        if (slv_req && !slv_gnt) begin
            lock_d = (sel_owner == OWN_DATA) ? LOCK_DATA : LOCK_INSTR;
        end else if (slv_req && slv_gnt) begin
            lock_d = LOCK_NONE;
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_owner = OWN_INSTR;
        unique case (lock_q)
            LOCK_INSTR: begin
                sel_valid = 1'b1;
                sel_owner = OWN_INSTR;
            end
            LOCK_DATA: begin
                sel_valid = 1'b1;
                sel_owner = OWN_DATA;
            end
            default: begin
                if (data_req && !(starve_cnt_q == STARVE_MAX && instr_req)) begin
                    sel_valid = 1'b1;
                    sel_owner = OWN_DATA;
                end else if (instr_req) begin
                    sel_valid = 1'b1;
                    sel_owner = OWN_INSTR;
                end
            end
        endcase
    end

    always_comb begin
        slv_req   = sel_valid && !fifo_full && !reset;
        slv_wr    = 1'b0;
        slv_addr  = '0;
        slv_wdata = '0;
        slv_be    = '0;
        if (sel_valid) begin
            if (sel_owner == OWN_DATA) begin
                slv_wr    = data_wr;
                slv_addr  = data_addr;
                slv_wdata = data_wdata;
                slv_be    = data_byteen;
            end else begin
                slv_addr  = instr_addr;
                slv_be    = FETCH_BE;
            end
        end
        instr_gnt = slv_req && slv_gnt && (sel_owner == OWN_INSTR);
        data_gnt  = slv_req && slv_gnt && (sel_owner == OWN_DATA);
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (instr_gnt) begin
            starve_cnt_d = '0;
        end else if (instr_req && data_gnt && starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    always_comb begin
        rsp_routed  = slv_valid && !fifo_empty && !reset;
        rsp_err     = slv_valid && fifo_empty && !reset;
        instr_valid = rsp_routed && (fifo_head == OWN_INSTR);
        data_valid  = rsp_routed && (fifo_head == OWN_DATA);
        instr_err   = instr_valid && slv_err;
        instr_rdata = slv_rdata;
        data_rdata  = slv_rdata;
    end

    owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (slv_req && slv_gnt),
        .push_owner (sel_owner),
        .pop        (rsp_routed),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scenario bench for bus_arbiter with default parameters (2 outstanding, starve limit 8).
module tb_bus_arbiter;

    localparam logic [31:0] IADDR = 32'h1000_0000;
    localparam logic [31:0] DADDR = 32'h2000_0040;
    localparam logic [31:0] WDATA = 32'hDEAD_BEEF;
    localparam logic [31:0] RDATA = 32'hCAFE_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic [31:0] instr_rdata;
    logic        instr_err;
    logic        instr_valid;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_byteen;
    logic        data_gnt;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        slv_req;
    logic        slv_wr;
    logic [31:0] slv_addr;
    logic [31:0] slv_wdata;
    logic [3:0]  slv_be;
    logic        slv_gnt;
    logic [31:0] slv_rdata;
    logic        slv_err;
    logic        slv_valid;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .OUTSTANDING  (2),
        .STARVE_LIMIT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_gnt   (instr_gnt),
        .instr_rdata (instr_rdata),
        .instr_err   (instr_err),
        .instr_valid (instr_valid),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_byteen (data_byteen),
        .data_gnt    (data_gnt),
        .data_rdata  (data_rdata),
        .data_valid  (data_valid),
        .slv_req     (slv_req),
        .slv_wr      (slv_wr),
        .slv_addr    (slv_addr),
        .slv_wdata   (slv_wdata),
        .slv_be      (slv_be),
        .slv_gnt     (slv_gnt),
        .slv_rdata   (slv_rdata),
        .slv_err     (slv_err),
        .slv_valid   (slv_valid),
        .rsp_err     (rsp_err)
    );

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req = 1'b0;
        data_req  = 1'b0;
        slv_gnt   = 1'b0;
        slv_valid = 1'b0;
        slv_err   = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        instr_req = 1'b1; data_req = 1'b1; slv_gnt = 1'b1; slv_valid = 1'b1;
        #1;
        checks++;
        if ({slv_req, instr_gnt, data_gnt} !== 3'b000) begin
            errors++; $display("FAIL reset_req_gnt got=%b exp=000", {slv_req, instr_gnt, data_gnt});
        end
        checks++;
        if ({instr_valid, data_valid, rsp_err, instr_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_rsp got=%b exp=0000", {instr_valid, data_valid, rsp_err, instr_err});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_priority();
        reset = 1'b0;
        instr_req = 1'b1; data_req = 1'b1; slv_gnt = 1'b1;
        #1;
        checks++;
        if ({data_gnt, instr_gnt} !== 2'b10) begin
            errors++; $display("FAIL prio_c0_gnt got=%b exp=10", {data_gnt, instr_gnt});
        end
        checks++;
        if ({slv_wr, slv_addr, slv_wdata, slv_be} !== {1'b1, DADDR, WDATA, 4'h3}) begin
            errors++; $display("FAIL prio_c0_bus got=%b/%h/%h/%h exp=1/%h/%h/3", slv_wr, slv_addr, slv_wdata, slv_be, DADDR, WDATA);
        end
        tick();
        data_req = 1'b0; slv_valid = 1'b1;
        #1;
        checks++;
        if ({instr_gnt, data_valid, instr_valid} !== 3'b110) begin
            errors++; $display("FAIL prio_c1 got=%b exp=110", {instr_gnt, data_valid, instr_valid});
        end
        checks++;
        if ({slv_wr, slv_addr, slv_wdata, slv_be} !== {1'b0, IADDR, 32'h0, 4'hF}) begin
            errors++; $display("FAIL prio_c1_bus got=%b/%h/%h/%h exp=0/%h/0/f", slv_wr, slv_addr, slv_wdata, slv_be, IADDR);
        end
        checks++;
        if (data_rdata !== RDATA) begin
            errors++; $display("FAIL prio_data_rdata got=%h exp=%h", data_rdata, RDATA);
        end
        tick();
        instr_req = 1'b0; slv_err = 1'b1;
        #1;
        checks++;
        if ({slv_req, instr_valid, data_valid, instr_err, rsp_err} !== 5'b01010) begin
            errors++; $display("FAIL prio_c2 got=%b exp=01010", {slv_req, instr_valid, data_valid, instr_err, rsp_err});
        end
        checks++;
        if (instr_rdata !== RDATA) begin
            errors++; $display("FAIL prio_instr_rdata got=%h exp=%h", instr_rdata, RDATA);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_starvation();
        int bad = 0;
        instr_req = 1'b1; data_req = 1'b1; slv_gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            slv_valid = (i > 0);
            #1;
            if (!data_gnt || instr_gnt || (i > 0 && !data_valid)) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL starve_data_phase got=%0d bad cycles exp=0", bad);
        end
        slv_valid = 1'b1;
        #1;
        checks++;
        if ({instr_gnt, data_gnt, data_valid} !== 3'b101) begin
            errors++; $display("FAIL starve_instr_wins got=%b exp=101", {instr_gnt, data_gnt, data_valid});
        end
        tick();
        checks++;
        if (dut.starve_cnt_q !== '0) begin
            errors++; $display("FAIL starve_cnt_clear got=%0d exp=0", dut.starve_cnt_q);
        end
        #1;
        checks++;
        if ({data_gnt, instr_gnt, instr_valid} !== 3'b101) begin
            errors++; $display("FAIL starve_data_back got=%b exp=101", {data_gnt, instr_gnt, instr_valid});
        end
        tick();
        instr_req = 1'b0; data_req = 1'b0;
        #1;
        checks++;
        if (data_valid !== 1'b1) begin
            errors++; $display("FAIL starve_drain got=%b exp=1", data_valid);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_lock();
        int bad = 0;
        instr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_req = (i > 0);
            #1;
            if (slv_addr !== IADDR || instr_gnt || data_gnt || !slv_req) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL lock_hold got=%0d bad cycles exp=0", bad);
        end
        slv_gnt = 1'b1;
        #1;
        checks++;
        if ({instr_gnt, data_gnt, slv_addr} !== {2'b10, IADDR}) begin
            errors++; $display("FAIL lock_release got=%b/%h exp=10/%h", {instr_gnt, data_gnt}, slv_addr, IADDR);
        end
        tick();
        instr_req = 1'b0; slv_valid = 1'b1;
        #1;
        checks++;
        if ({data_gnt, instr_valid, slv_addr} !== {2'b11, DADDR}) begin
            errors++; $display("FAIL lock_data_after got=%b/%h exp=11/%h", {data_gnt, instr_valid}, slv_addr, DADDR);
        end
        tick();
        data_req = 1'b0;
        #1;
        checks++;
        if (data_valid !== 1'b1) begin
            errors++; $display("FAIL lock_drain got=%b exp=1", data_valid);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_outstanding();
        data_req = 1'b1; slv_gnt = 1'b1;
        #1;
        checks++;
        if (data_gnt !== 1'b1) begin
            errors++; $display("FAIL out_g0 got=%b exp=1", data_gnt);
        end
        tick();
        #1;
        checks++;
        if (data_gnt !== 1'b1) begin
            errors++; $display("FAIL out_g1 got=%b exp=1", data_gnt);
        end
        tick();
        #1;
        checks++;
        if ({slv_req, data_gnt} !== 2'b00) begin
            errors++; $display("FAIL out_full got=%b exp=00", {slv_req, data_gnt});
        end
        tick();
        slv_valid = 1'b1;
        #1;
        checks++;
        if ({slv_req, data_gnt, data_valid} !== 3'b001) begin
            errors++; $display("FAIL out_no_bypass got=%b exp=001", {slv_req, data_gnt, data_valid});
        end
        tick();
        #1;
        checks++;
        if ({data_gnt, data_valid} !== 2'b11) begin
            errors++; $display("FAIL out_push_pop got=%b exp=11", {data_gnt, data_valid});
        end
        tick();
        data_req = 1'b0;
        #1;
        checks++;
        if ({data_valid, rsp_err} !== 2'b10) begin
            errors++; $display("FAIL out_last got=%b exp=10", {data_valid, rsp_err});
        end
        tick();
        #1;
        checks++;
        if ({rsp_err, instr_valid, data_valid} !== 3'b100) begin
            errors++; $display("FAIL empty_rsp_err got=%b exp=100", {rsp_err, instr_valid, data_valid});
        end
        tick();
        slv_valid = 1'b0;
        #1;
        checks++;
        if (rsp_err !== 1'b0) begin
            errors++; $display("FAIL rsp_err_pulse got=%b exp=0", rsp_err);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_outstanding();
        data_req = 1'b1; slv_gnt = 1'b1;
        tick();
        tick();
        reset = 1'b1; slv_valid = 1'b1; instr_req = 1'b1;
        #1;
        checks++;
        if ({slv_req, instr_gnt, data_gnt, instr_valid, data_valid, rsp_err} !== 6'b0) begin
            errors++; $display("FAIL rst_out_outputs got=%b exp=000000",
                {slv_req, instr_gnt, data_gnt, instr_valid, data_valid, rsp_err});
        end
        tick();
        reset = 1'b0; instr_req = 1'b0; data_req = 1'b0;
        #1;
        checks++;
        if ({rsp_err, instr_valid, data_valid} !== 3'b100) begin
            errors++; $display("FAIL rst_out_stale_rsp got=%b exp=100", {rsp_err, instr_valid, data_valid});
        end
        tick();
        slv_valid = 1'b0; data_req = 1'b1;
        #1;
        checks++;
        if (data_gnt !== 1'b1) begin
            errors++; $display("FAIL rst_out_fifo_empty got=%b exp=1", data_gnt);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        reset       = 1'b1;
        instr_addr  = IADDR;
        data_addr   = DADDR;
        data_wdata  = WDATA;
        data_byteen = 4'h3;
        data_wr     = 1'b1;
        slv_rdata   = RDATA;
        idle_inputs();

        test_reset();
        test_priority();
        test_starvation();
        test_lock();
        test_outstanding();
        test_reset_outstanding();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
